rx_frame_ctrl: RTL and testbench

Controller that sequences the 8-bit UART receiver output into framed packets for the rest of the design. It detects each completed byte from the receiver and hunts for a sync byte. It then collects a length byte, payload and checksum into a local buffer, and hands a verified frame to one consumer over a valid/ready handshake. Error and timeout conditions return it to sync hunting without consumer involvement.

---
 rtl/rx_frame_pkg.sv | 21 ++
 rtl/rx_frame_buf.sv | 25 ++
 rtl/rx_frame_ctrl.sv | 175 +++++++++++++++++
 tb/tb_rx_frame_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rx_frame_pkg.sv
// Shared types and defaults for the UART frame receiver slice.
// No logic here: state encoding plus width/constant defaults.
package rx_frame_pkg;

    typedef enum logic [2:0] {
        HUNT,
        LEN,
        PAY,
        CHK,
        HOLD
    } state_t;

    localparam logic [7:0] SYNC_DEF    = 8'hA5;
    localparam int         MAX_LEN_DEF = 16;
    localparam int         TIMEOUT_DEF = 4096;

    // Index addresses up to 16 payload bytes; length also needs to encode 16 itself.
    localparam int IDX_W = 4;
    localparam int LEN_W = 5;

endpackage

// File: rtl/rx_frame_buf.sv
// Payload register file: synchronous write, combinational read, no reset on storage.
// Write lands on the clock edge; read reflects storage the same cycle; no backpressure.
module rx_frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rx_frame_ctrl.sv
// Frames receiver bytes (sync, length, payload, checksum) into a buffer and holds a verified frame.
// Byte handled on the edge after rx_en rises; frame held until frame_ready, later bytes dropped as overrun.
module rx_frame_ctrl
    import rx_frame_pkg::*;
#(
    parameter int         MAX_LEN = MAX_LEN_DEF,
    parameter logic [7:0] SYNC    = SYNC_DEF,
    parameter int         TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             rx_en,
    input  logic             frame_ready,
    input  logic [IDX_W-1:0] rd_addr,
    output logic             frame_valid,
    output logic [LEN_W-1:0] frame_len,
    output logic [7:0]       rd_data,
    output logic             err_chk,
    output logic             err_len,
    output logic             err_tout,
    output logic             overrun,
    output logic             busy
);

    localparam int              TW        = $clog2(TIMEOUT);
    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0]   TOUT_LAST = TW'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             rx_en_q;
    logic [LEN_W-1:0] len_q, len_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       sum_q, sum_d;
    logic [TW-1:0]    tout_q, tout_d;
    logic             err_chk_q, err_chk_d;
    logic             err_len_q, err_len_d;
    logic             err_tout_q, err_tout_d;
    logic             overrun_q, overrun_d;
    logic             byte_ev;
    logic             in_frame;
    logic             tout_hit;
    logic             last_pay;
    logic             buf_we;

    assign byte_ev  = rx_en & ~rx_en_q;
    assign in_frame = (state_q == LEN) || (state_q == PAY) || (state_q == CHK);
    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign tout_hit = in_frame && !byte_ev && (tout_q == TOUT_LAST);
    assign last_pay = ({1'b0, idx_q} == (len_q - LEN_W'(1)));

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        sum_d      = sum_q;
        err_chk_d  = 1'b0;
        err_len_d  = 1'b0;
        err_tout_d = 1'b0;
        overrun_d  = 1'b0;
        buf_we     = 1'b0;

        if (!in_frame || byte_ev || tout_hit) begin
            tout_d = '0;
        end else begin
            tout_d = tout_q + TW'(1);
        end

        unique case (state_q)
            HUNT: begin
                if (byte_ev && (rx_data == SYNC)) begin
                    state_d = LEN;
                end
            end
            LEN: begin
                if (byte_ev) begin
                    if (rx_data > MAX_LEN_B) begin
                        err_len_d = 1'b1;
                        state_d   = HUNT;
                    end else begin
                        len_d   = LEN_W'(rx_data);
                        idx_d   = '0;
                        sum_d   = rx_data;
                        state_d = (rx_data == 8'd0) ? CHK : PAY;
                    end
                end else if (tout_hit) begin
                    err_tout_d = 1'b1;
                    state_d    = HUNT;
                end
            end
            PAY: begin
                if (byte_ev) begin
                    buf_we = 1'b1;
                    sum_d  = sum_q + rx_data;
                    if (last_pay) begin
                        state_d = CHK;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (tout_hit) begin
                    err_tout_d = 1'b1;
                    state_d    = HUNT;
                end
            end
            CHK: begin
                if (byte_ev) begin
                    if (rx_data == sum_q) begin
                        state_d = HOLD;
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = HUNT;
                    end
                end else if (tout_hit) begin
                    err_tout_d = 1'b1;
                    state_d    = HUNT;
                end
            end
            HOLD: begin
                overrun_d = byte_ev;
                if (frame_ready) begin
                    state_d = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    // rx_en_q resets high so a level already present at reset release is not a byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= HUNT;
            rx_en_q    <= 1'b1;
            len_q      <= '0;
            idx_q      <= '0;
            sum_q      <= '0;
            tout_q     <= '0;
            err_chk_q  <= 1'b0;
            err_len_q  <= 1'b0;
            err_tout_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_en_q    <= rx_en;
            len_q      <= len_d;
            idx_q      <= idx_d;
            sum_q      <= sum_d;
            tout_q     <= tout_d;
            err_chk_q  <= err_chk_d;
            err_len_q  <= err_len_d;
            err_tout_q <= err_tout_d;
            overrun_q  <= overrun_d;
        end
    end

    rx_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (IDX_W)
    ) u_buf (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (idx_q),
        .wdata_i (rx_data),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    assign frame_valid = (state_q == HOLD);
    assign frame_len   = len_q;
    assign busy        = (state_q != HUNT);
    assign err_chk     = err_chk_q;
    assign err_len     = err_len_q;
    assign err_tout    = err_tout_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed bench for rx_frame_ctrl: frames, error paths, timeout, overrun and reset.
module tb_rx_frame_ctrl;

    localparam int TIMEOUT = 4096;

    logic       clk;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_en;
    logic       frame_ready;
    logic [3:0] rd_addr;
    logic       frame_valid;
    logic [4:0] frame_len;
    logic [7:0] rd_data;
    logic       err_chk;
    logic       err_len;
    logic       err_tout;
    logic       overrun;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    int n_chk   = 0;
    int n_len   = 0;
    int n_tout  = 0;
    int n_ovr   = 0;
    int n_valid = 0;

    rx_frame_ctrl #(
        .MAX_LEN (16),
        .SYNC    (8'hA5),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_en       (rx_en),
        .frame_ready (frame_ready),
        .rd_addr     (rd_addr),
        .frame_valid (frame_valid),
        .frame_len   (frame_len),
        .rd_data     (rd_data),
        .err_chk     (err_chk),
        .err_len     (err_len),
        .err_tout    (err_tout),
        .overrun     (overrun),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters: a one-cycle pulse adds exactly one.
    always @(negedge clk) begin
        if (reset) begin
            n_chk   <= n_chk + int'(err_chk);
            n_len   <= n_len + int'(err_len);
            n_tout  <= n_tout + int'(err_tout);
            n_ovr   <= n_ovr + int'(overrun);
            n_valid <= n_valid + int'(frame_valid);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_en   = 1'b1;
        repeat (3) @(negedge clk);
        rx_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic release_frame();
        @(negedge clk);
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
    endtask

    initial begin
        int c_chk, c_len, c_tout, c_ovr, c_valid;
        int seen_at;

        reset       = 1'b0;
        rx_data     = 8'h00;
        rx_en       = 1'b0;
        frame_ready = 1'b0;
        rd_addr     = 4'd0;
        repeat (3) @(negedge clk);

        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_len",   32'(frame_len),   32'd0);
        check("rst_busy",  32'(busy),        32'd0);
        check("rst_errs",  32'({err_chk, err_len, err_tout, overrun}), 32'd0);

        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Good frame: 03+11+22+33 = 69.
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
        check("good_valid", 32'(frame_valid), 32'd1);
        check("good_len",   32'(frame_len),   32'd3);
        rd_addr = 4'd0; #1 check("good_rd0", 32'(rd_data), 32'h11);
        rd_addr = 4'd1; #1 check("good_rd1", 32'(rd_data), 32'h22);
        rd_addr = 4'd2; #1 check("good_rd2", 32'(rd_data), 32'h33);
        repeat (5) @(negedge clk);
        check("good_hold", 32'(frame_valid), 32'd1);
        release_frame();
        check("good_rel_valid", 32'(frame_valid), 32'd0);
        check("good_rel_busy",  32'(busy),        32'd0);

        // Bad checksum: 02+10+20 = 32, sent 31.
        c_chk = n_chk; c_valid = n_valid;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
        send_byte(8'h20); send_byte(8'h31);
        @(negedge clk);
        check("chk_pulse",   32'(n_chk - c_chk),     32'd1);
        check("chk_novalid", 32'(n_valid - c_valid), 32'd0);
        check("chk_busy",    32'(busy),              32'd0);

        // Length 17 is rejected, then a zero-length frame with ready already high.
        c_len = n_len;
        send_byte(8'hA5); send_byte(8'h11);
        @(negedge clk);
        check("len_pulse", 32'(n_len - c_len), 32'd1);
        check("len_busy",  32'(busy),          32'd0);
        c_valid = n_valid;
        frame_ready = 1'b1;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
        check("len0_valid_1cyc", 32'(n_valid - c_valid), 32'd1);
        check("len0_len",        32'(frame_len),         32'd0);
        check("len0_busy",       32'(busy),              32'd0);
        frame_ready = 1'b0;

        // Timeout: last event is processed a half cycle after send_byte raises rx_en;
        // the counter needs TIMEOUT-1 further edges, then one edge to register the pulse.
        c_tout = n_tout;
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
        seen_at = -1;
        for (int i = 1; i <= TIMEOUT + 8; i++) begin
            @(negedge clk);
            if (err_tout && seen_at < 0) seen_at = i;
        end
        check("tout_when_ok", 32'((seen_at >= TIMEOUT - 5) && (seen_at <= TIMEOUT - 3)), 32'd1);
        check("tout_pulse",   32'(n_tout - c_tout), 32'd1);
        check("tout_busy",    32'(busy),            32'd0);
        // 01+7E = 7F
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
        check("post_tout_valid", 32'(frame_valid), 32'd1);
        rd_addr = 4'd0; #1 check("post_tout_rd0", 32'(rd_data), 32'h7E);

        // Sync byte while holding is an overrun and leaves the frame alone.
        c_ovr = n_ovr;
        send_byte(8'hA5);
        check("ovr_pulse", 32'(n_ovr - c_ovr), 32'd1);
        check("ovr_valid", 32'(frame_valid),   32'd1);
        check("ovr_len",   32'(frame_len),     32'd1);
        #1 check("ovr_rd0", 32'(rd_data), 32'h7E);
        release_frame();

        // Garbage before sync is silent. 02+01+02 = 05.
        c_chk = n_chk; c_len = n_len; c_tout = n_tout; c_ovr = n_ovr;
        send_byte(8'h00); send_byte(8'hFF);
        check("garbage_busy", 32'(busy), 32'd0);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01);
        send_byte(8'h02); send_byte(8'h05);
        check("garbage_noerr", 32'((n_chk - c_chk) + (n_len - c_len) + (n_tout - c_tout) + (n_ovr - c_ovr)), 32'd0);
        check("garbage_len", 32'(frame_len), 32'd2);
        rd_addr = 4'd1; #1 check("garbage_rd1", 32'(rd_data), 32'h02);
        release_frame();

        // Reset in mid-payload with rx_en held high across the release.
        send_byte(8'hA5); send_byte(8'h05); send_byte(8'h01);
        check("mid_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rx_data = 8'hA5;
        rx_en   = 1'b1;
        reset   = 1'b0;
        #1;
        check("mid_rst_outs", 32'({frame_valid, frame_len, busy, err_chk, err_len, err_tout, overrun}), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("rel_high_no_event", 32'(busy), 32'd0);
        rx_en = 1'b0;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
        check("post_rst_valid", 32'(frame_valid), 32'd1);
        release_frame();
        check("post_rst_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
